// File: rtl/riscv_test_sequencer_if.sv
// Handshake/status bundle between the compliance test sequencer and its surroundings
// (CPU debug port, program loader, board display). Master = environment, slave = sequencer.
// Widths follow the sequencer parameters; keep NUM_TESTS/CYC_W/CNT_W identical on both.
interface riscv_test_sequencer_if #(
  parameter int unsigned NUM_TESTS = 38,
  parameter int unsigned CYC_W     = 16,
  parameter int unsigned CNT_W     = 8
) ();
  localparam int unsigned TID_W = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1;

  // environment -> sequencer
  logic             start;
  logic             abort;
  logic             single;
  logic [TID_W-1:0] test_id;
  logic [31:0]      instr;
  logic [31:0]      result;
  logic             load_done;

  // sequencer -> environment
  logic             load_req;
  logic [TID_W-1:0] test_sel;
  logic             cpu_rst;
  logic             busy;
  logic             done;
  logic             status_valid;
  logic [1:0]       last_status;
  logic [CYC_W-1:0] last_cycles;
  logic [CNT_W-1:0] pass_count;
  logic [CNT_W-1:0] fail_count;
  logic [CNT_W-1:0] unknown_count;
  logic [CNT_W-1:0] timeout_count;

  modport master (
    output start, abort, single, test_id, instr, result, load_done,
    input  load_req, test_sel, cpu_rst, busy, done, status_valid,
           last_status, last_cycles, pass_count, fail_count, unknown_count, timeout_count
  );

  modport slave (
    input  start, abort, single, test_id, instr, result, load_done,
    output load_req, test_sel, cpu_rst, busy, done, status_valid,
           last_status, last_cycles, pass_count, fail_count, unknown_count, timeout_count
  );
endinterface

// File: rtl/riscv_test_sequencer.sv
// Runs a batch of compliance programs on the CPU: load, hold reset, run to halt/watchdog, classify x10.
// Latency: LOAD waits on load_done, HOLD is RST_CYCLES, RUN up to MAX_CYCLES, then CHECK and NEXT one cycle each.
// Backpressure: load_req is held until load_done; start is ignored while busy; abort returns to IDLE next cycle.
module riscv_test_sequencer #(
  parameter int unsigned NUM_TESTS  = 38,
  parameter int unsigned MAX_CYCLES = 10000,
  parameter int unsigned CYC_W      = 16,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned RST_CYCLES = 2,
  parameter logic [31:0] HALT_INSTR = 32'hdead10cc,
  parameter logic [31:0] PASS_MAGIC = 32'h00c0ffee,
  parameter logic [31:0] FAIL_MAGIC = 32'hdeaddead
) (
  input logic                   clock,
  input logic                   reset,
  riscv_test_sequencer_if.slave bus
);
  localparam int unsigned TID_W  = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1;
  localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [TID_W-1:0]  LAST_TEST = TID_W'(NUM_TESTS - 1);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(MAX_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT   = {CNT_W{1'b1}};

  localparam logic [1:0] ST_PASS    = 2'd0;
  localparam logic [1:0] ST_FAIL    = 2'd1;
  localparam logic [1:0] ST_UNKNOWN = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HOLD, S_RUN, S_CHECK, S_NEXT, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [TID_W-1:0]  test_sel_q;
  logic              single_q;
  logic [HOLD_W-1:0] hold_q;
  logic [CYC_W-1:0]  cyc_q;
  logic [31:0]       res_q;
  logic              tmo_q;
  logic [1:0]        last_status_q;
  logic [CYC_W-1:0]  last_cycles_q;
  logic [CNT_W-1:0]  pass_q, fail_q, unk_q, tmo_cnt_q;
  logic              status_valid_q, load_req_q, cpu_rst_q, busy_q, done_q;

  logic              is_halt;
  logic              last_test;
  logic [TID_W-1:0]  start_sel;
  logic [1:0]        status_d;

  assign is_halt   = (bus.instr == HALT_INSTR);
  assign last_test = single_q || (test_sel_q == LAST_TEST);

  // First test of a batch: requested index (clamped into range) in single mode, else test 0.
  always_comb begin
    start_sel = '0;
    if (bus.single) begin
      start_sel = (32'(bus.test_id) >= NUM_TESTS) ? LAST_TEST : bus.test_id;
    end
  end

  // Classification of the finished test; a watchdog expiry overrides the captured x10.
  always_comb begin
    status_d = ST_UNKNOWN;
    if (tmo_q)                    status_d = ST_TIMEOUT;
    else if (res_q == PASS_MAGIC) status_d = ST_PASS;
    else if (res_q == FAIL_MAGIC) status_d = ST_FAIL;
  end

  // Next-state decision; abort overrides every transition, halt beats the watchdog.
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (bus.start) state_d = S_LOAD;
        S_LOAD:         if (bus.load_done) state_d = S_HOLD;
        S_HOLD:         if (hold_q == HOLD_LAST) state_d = S_RUN;
        S_RUN:          if (is_halt || (cyc_q == CYC_LAST)) state_d = S_CHECK;
        S_CHECK:        state_d = S_NEXT;
        S_NEXT:         state_d = last_test ? S_DONE : S_LOAD;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // FSM state, registered outputs derived from the next state, and the per-test datapath.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      test_sel_q     <= '0;
      single_q       <= 1'b0;
      hold_q         <= '0;
      cyc_q          <= '0;
      res_q          <= '0;
      tmo_q          <= 1'b0;
      last_status_q  <= ST_PASS;
      last_cycles_q  <= '0;
      pass_q         <= '0;
      fail_q         <= '0;
      unk_q          <= '0;
      tmo_cnt_q      <= '0;
      status_valid_q <= 1'b0;
      load_req_q     <= 1'b0;
      cpu_rst_q      <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      load_req_q     <= (state_d == S_LOAD);
      cpu_rst_q      <= !((state_d == S_RUN) || (state_d == S_CHECK));
      busy_q         <= !((state_d == S_IDLE) || (state_d == S_DONE));
      done_q         <= (state_d == S_DONE);
      status_valid_q <= 1'b0;
      if (!bus.abort) begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (bus.start) begin
              pass_q        <= '0;
              fail_q        <= '0;
              unk_q         <= '0;
              tmo_cnt_q     <= '0;
              last_status_q <= ST_PASS;
              last_cycles_q <= '0;
              single_q      <= bus.single;
              test_sel_q    <= start_sel;
            end
          end
          S_LOAD: hold_q <= '0;
          S_HOLD: begin
            // cyc/tmo are cleared every HOLD cycle so RUN always starts from 0.
            hold_q <= hold_q + 1'b1;
            cyc_q  <= '0;
            tmo_q  <= 1'b0;
          end
          S_RUN: begin
            if (is_halt) begin
              res_q <= bus.result;
            end else if (cyc_q == CYC_LAST) begin
              tmo_q <= 1'b1;
            end else begin
              cyc_q <= cyc_q + 1'b1;
            end
          end
          S_CHECK: begin
            last_status_q  <= status_d;
            last_cycles_q  <= cyc_q;
            status_valid_q <= 1'b1;
            case (status_d)
              ST_PASS:    if (pass_q    != CNT_SAT) pass_q    <= pass_q + 1'b1;
              ST_FAIL:    if (fail_q    != CNT_SAT) fail_q    <= fail_q + 1'b1;
              ST_UNKNOWN: if (unk_q     != CNT_SAT) unk_q     <= unk_q + 1'b1;
              default:    if (tmo_cnt_q != CNT_SAT) tmo_cnt_q <= tmo_cnt_q + 1'b1;
            endcase
          end
          S_NEXT: if (!last_test) test_sel_q <= test_sel_q + 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign bus.load_req      = load_req_q;
  assign bus.test_sel      = test_sel_q;
  assign bus.cpu_rst       = cpu_rst_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.status_valid  = status_valid_q;
  assign bus.last_status   = last_status_q;
  assign bus.last_cycles   = last_cycles_q;
  assign bus.pass_count    = pass_q;
  assign bus.fail_count    = fail_q;
  assign bus.unknown_count = unk_q;
  assign bus.timeout_count = tmo_cnt_q;
endmodule

// File: tb/tb_riscv_test_sequencer.sv
// Bench for riscv_test_sequencer: directed scenario steps with randomized latencies/halts/results,
// checked against a per-test outcome model (status from halt position and x10, saturating totals).
module tb_riscv_test_sequencer;
  localparam int NT   = 5;
  localparam int MC   = 50;
  localparam int CYW  = 8;
  localparam int CNW  = 2;
  localparam int RC   = 2;
  localparam int TW   = $clog2(NT);
  localparam int CMAX = (1 << CNW) - 1;
  localparam logic [31:0] HALT      = 32'hdead10cc;
  localparam logic [31:0] MAGIC_OK  = 32'h00c0ffee;
  localparam logic [31:0] MAGIC_BAD = 32'hdeaddead;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  riscv_test_sequencer_if #(.NUM_TESTS(NT), .CYC_W(CYW), .CNT_W(CNW)) bus ();

  riscv_test_sequencer #(
    .NUM_TESTS(NT), .MAX_CYCLES(MC), .CYC_W(CYW), .CNT_W(CNW), .RST_CYCLES(RC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  int m_cnt [4];          // model totals: pass, fail, unknown, timeout
  int h_tab [NT];         // halt cycle per test (-1 = never halts)
  int l_tab [NT];         // load latency per test
  logic [31:0] r_tab [NT];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] v;
    v = $urandom;
    if (v == HALT) v = ~v;
    return v;
  endfunction

  function automatic logic [31:0] rand_result();
    logic [31:0] v;
    case ($urandom_range(0, 2))
      0:       v = MAGIC_OK;
      1:       v = MAGIC_BAD;
      default: begin
        v = $urandom;
        if (v == MAGIC_OK || v == MAGIC_BAD) v = 32'h12345678;
      end
    endcase
    return v;
  endfunction

  function automatic int exp_status(input int halt_at, input logic [31:0] res);
    if (halt_at < 0 || halt_at >= MC) return 3;
    if (res == MAGIC_OK)  return 0;
    if (res == MAGIC_BAD) return 1;
    return 2;
  endfunction

  task automatic chk_totals(input string tag);
    chk({tag, "_pass"},    bus.pass_count,    m_cnt[0]);
    chk({tag, "_fail"},    bus.fail_count,    m_cnt[1]);
    chk({tag, "_unknown"}, bus.unknown_count, m_cnt[2]);
    chk({tag, "_timeout"}, bus.timeout_count, m_cnt[3]);
  endtask

  // Pulse start for one cycle; afterwards the batch totals must read as cleared.
  task automatic pulse_start(input bit s, input int id);
    @(negedge clock);
    bus.start   = 1'b1;
    bus.single  = s;
    bus.test_id = TW'(id);
    @(negedge clock);
    bus.start  = 1'b0;
    bus.single = ~s;   // mode must have been latched at start
    foreach (m_cnt[i]) m_cnt[i] = 0;
    chk_totals("start_clear");
    chk("start_clear_cycles", bus.last_cycles, 0);
    chk("start_clear_status", bus.last_status, 0);
  endtask

  // LOAD handshake then HOLD: cpu_rst must stay high exactly RC cycles after load_done.
  task automatic load_phase(input int exp_sel, input int lat);
    int n;
    int hold;
    n = 0;
    while (bus.load_req !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("load_req", bus.load_req, 1);
    chk("test_sel", bus.test_sel, exp_sel);
    chk("load_cpu_rst", bus.cpu_rst, 1);
    chk("load_busy", bus.busy, 1);
    repeat (lat) @(negedge clock);
    chk("load_req_held", bus.load_req, 1);
    bus.load_done = 1'b1;
    @(negedge clock);
    bus.load_done = 1'b0;
    hold = 0;
    while (bus.cpu_rst === 1'b1 && hold < 10) begin
      @(negedge clock);
      hold++;
    end
    chk("hold_cycles", hold, RC);
    chk("run_load_req", bus.load_req, 0);
  endtask

  // Drive RUN until halt/watchdog, then check the CHECK cycle and the status update after it.
  task automatic run_phase(input int halt_at, input logic [31:0] res, input bit poke_start);
    int e;
    int st;
    int sv;
    int bad_rst;
    e  = (halt_at >= 0 && halt_at < MC) ? halt_at : MC - 1;
    st = exp_status(halt_at, res);
    sv = 0;
    bad_rst = 0;
    for (int k = 0; k <= e; k++) begin
      bus.instr  = (k == halt_at) ? HALT : rand_instr();
      bus.result = (k == halt_at) ? res : $urandom;
      bus.start  = poke_start && (k == 5);
      if (bus.cpu_rst !== 1'b0) bad_rst++;
      if (bus.status_valid !== 1'b0) sv++;
      @(negedge clock);
    end
    bus.start  = 1'b0;
    bus.instr  = rand_instr();
    bus.result = $urandom;
    chk("run_cpu_rst_low", bad_rst, 0);
    chk("run_no_status", sv, 0);
    chk("check_cpu_rst", bus.cpu_rst, 0);
    chk("check_no_status", bus.status_valid, 0);
    @(negedge clock);
    if (m_cnt[st] < CMAX) m_cnt[st]++;
    chk("status_valid", bus.status_valid, 1);
    chk("last_status", bus.last_status, st);
    chk("last_cycles", bus.last_cycles, e);
    chk_totals("totals");
    chk("next_cpu_rst", bus.cpu_rst, 1);
    @(negedge clock);
    chk("status_valid_pulse", bus.status_valid, 0);
  endtask

  task automatic run_batch(input bit poke_t1);
    pulse_start(1'b0, $urandom_range(0, NT - 1));
    for (int t = 0; t < NT; t++) begin
      load_phase(t, l_tab[t]);
      run_phase(h_tab[t], r_tab[t], poke_t1 && (t == 1));
    end
    chk("batch_done", bus.done, 1);
    chk("batch_busy", bus.busy, 0);
    chk("batch_cpu_rst", bus.cpu_rst, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    bus.start = 0; bus.abort = 0; bus.single = 0; bus.test_id = '0;
    bus.instr = '0; bus.result = '0; bus.load_done = 0;
    foreach (m_cnt[i]) m_cnt[i] = 0;

    // Reset values
    repeat (2) @(negedge clock);
    chk("rst_cpu_rst", bus.cpu_rst, 1);
    chk("rst_test_sel", bus.test_sel, 0);
    chk("rst_load_req", bus.load_req, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_status_valid", bus.status_valid, 0);
    chk("rst_last_status", bus.last_status, 0);
    chk("rst_last_cycles", bus.last_cycles, 0);
    chk_totals("rst");
    reset = 1'b1;

    // load_done outside LOAD is ignored
    @(negedge clock);
    bus.load_done = 1'b1;
    repeat (2) @(negedge clock);
    bus.load_done = 1'b0;
    chk("idle_load_done_busy", bus.busy, 0);
    chk("idle_load_done_req", bus.load_req, 0);

    // Single mode test 3, halt on RUN cycle 40 with pass value
    pulse_start(1'b1, 3);
    load_phase(3, 2);
    run_phase(40, MAGIC_OK, 1'b0);
    chk("single_done", bus.done, 1);
    chk("single_busy", bus.busy, 0);
    repeat (3) @(negedge clock);
    chk("done_hold", bus.done, 1);
    chk("done_no_status", bus.status_valid, 0);

    // Batch with mixed results; start pulsed during RUN of test 1 must be ignored
    r_tab[0] = MAGIC_OK; r_tab[1] = MAGIC_BAD; r_tab[2] = 32'h12345678;
    r_tab[3] = MAGIC_OK; r_tab[4] = MAGIC_OK;
    for (int t = 0; t < NT; t++) begin
      l_tab[t] = $urandom_range(0, 4);
      h_tab[t] = $urandom_range(10, 45);
    end
    run_batch(1'b1);

    // Restart from DONE: timeout, halt exactly on the last allowed cycle, then random tests
    h_tab[0] = -1;      r_tab[0] = MAGIC_OK;
    h_tab[1] = MC - 1;  r_tab[1] = MAGIC_BAD;
    for (int t = 2; t < NT; t++) begin
      h_tab[t] = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, MC - 1);
      r_tab[t] = rand_result();
    end
    for (int t = 0; t < NT; t++) l_tab[t] = $urandom_range(0, 4);
    run_batch(1'b0);

    // All passing: pass_count saturates
    for (int t = 0; t < NT; t++) begin
      l_tab[t] = $urandom_range(0, 3);
      h_tab[t] = $urandom_range(0, MC - 1);
      r_tab[t] = MAGIC_OK;
    end
    run_batch(1'b0);

    // Fully random batches
    for (int b = 0; b < 2; b++) begin
      for (int t = 0; t < NT; t++) begin
        l_tab[t] = $urandom_range(0, 5);
        h_tab[t] = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, MC + 5);
        r_tab[t] = rand_result();
      end
      run_batch(1'b0);
    end

    // Out-of-range single index clamps to the last test
    pulse_start(1'b1, 6);
    load_phase(NT - 1, 1);
    run_phase($urandom_range(0, MC - 1), rand_result(), 1'b0);
    chk("clamp_done", bus.done, 1);

    // Abort on RUN cycle 10 of the second test: totals retained, no status pulse
    pulse_start(1'b0, 0);
    load_phase(0, 1);
    run_phase(12, MAGIC_OK, 1'b0);
    load_phase(1, 0);
    for (int k = 0; k < 10; k++) begin
      bus.instr = rand_instr();
      @(negedge clock);
    end
    bus.instr = rand_instr();
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_cpu_rst", bus.cpu_rst, 1);
    chk("abort_load_req", bus.load_req, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_no_status", bus.status_valid, 0);
    chk("abort_last_cycles", bus.last_cycles, 12);
    chk_totals("abort");
    repeat (3) @(negedge clock);
    chk("abort_still_idle", bus.busy, 0);
    chk("abort_late_status", bus.status_valid, 0);

    // Asynchronous reset in LOAD with non-zero totals
    pulse_start(1'b0, 0);
    load_phase(0, 0);
    run_phase(7, MAGIC_BAD, 1'b0);
    chk("pre_reset_load_req", bus.load_req, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("areset_load_req", bus.load_req, 0);
    chk("areset_busy", bus.busy, 0);
    chk("areset_cpu_rst", bus.cpu_rst, 1);
    chk("areset_test_sel", bus.test_sel, 0);
    chk("areset_last_cycles", bus.last_cycles, 0);
    foreach (m_cnt[i]) m_cnt[i] = 0;
    chk_totals("areset");
    @(negedge clock);
    reset = 1'b1;

    // Asynchronous reset in RUN forces cpu_rst high without a clock edge
    pulse_start(1'b1, 1);
    load_phase(1, 0);
    repeat (3) begin
      bus.instr = rand_instr();
      @(negedge clock);
    end
    chk("run_before_reset", bus.cpu_rst, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("areset_run_cpu_rst", bus.cpu_rst, 1);
    chk("areset_run_busy", bus.busy, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/riscv_test_sequencer.md
Name: riscv_test_sequencer

Overview:
- Synthesizable, parametrised sequencer that runs a batch of RISC-V compliance programs on the single-cycle CPU without a simulator, so the pass/fail flow also works on the FPGA board.
- For each test in turn, it:
  - requests a program load;
  - holds the CPU in reset;
  - counts execution cycles until the halt instruction or a watchdog limit;
  - classifies the x10 result and accumulates per-category counts.
- It sits beside the CPU, the instruction/data memory loader and the board debug display.

Parameters:
NUM_TESTS, 38, number of test programs in the batch (index range 0..NUM_TESTS-1)
MAX_CYCLES, 10000, watchdog limit in CPU cycles per test
CYC_W, 16, width of the cycle counter and last_cycles; must hold MAX_CYCLES
CNT_W, 8, width of the pass/fail/unknown/timeout counters
RST_CYCLES, 2, cycles cpu_rst is held asserted after a load completes
HALT_INSTR, 32'hdead10cc, instruction word that ends a test
PASS_MAGIC, 32'h00c0ffee, x10 value meaning pass
FAIL_MAGIC, 32'hdeaddead, x10 value meaning fail

Ports:
clock  in  1  system clock, all state on the rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a batch from IDLE or DONE; ignored while busy
abort  in  1  synchronous; any state except IDLE goes to IDLE next cycle; counters retained
single  in  1  sampled on start; 1 = run only test_id, 0 = run 0..NUM_TESTS-1
test_id  in  $clog2(NUM_TESTS)  test index used when single=1
instr  in  32  CPU fetched instruction (InstrMemdataout)
result  in  32  CPU register x10 via debug port
load_done  in  1  loader has finished writing test_sel program and data images
load_req  out  1  level; high in LOAD until load_done is seen
test_sel  out  $clog2(NUM_TESTS)  index of the test being loaded or run
cpu_rst  out  1  active-high reset to the CPU; high in every state except RUN and CHECK
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE
status_valid  out  1  one-cycle pulse when last_* updates
last_status  out  2  0 = PASS, 1 = FAIL, 2 = UNKNOWN, 3 = TIMEOUT
last_cycles  out  CYC_W  cycle count of the last completed test
pass_count, fail_count, unknown_count, timeout_count  out  CNT_W each  batch totals

Behaviour:
- Reset values (reset=0, asynchronous):
  - state=IDLE, cpu_rst=1, test_sel=0.
  - All counters, last_status and last_cycles are 0.
  - load_req, busy, done and status_valid are 0.
- FSM states and transitions:
  - IDLE: wait for start.
  - LOAD: load_req=1; go to HOLD on the first cycle load_done=1.
  - HOLD: cpu_rst=1 for exactly RST_CYCLES cycles, then RUN.
  - RUN: cpu_rst=0; cyc clears to 0 on entry. Each RUN cycle is evaluated in this order:
    - if instr==HALT_INSTR, capture result and go to CHECK; halt has priority over the watchdog in the same cycle;
    - else if cyc==MAX_CYCLES-1, go to CHECK marked TIMEOUT;
    - else cyc++.
  - CHECK: one cycle. Classify the captured value:
    - ==PASS_MAGIC -> PASS;
    - ==FAIL_MAGIC -> FAIL;
    - otherwise UNKNOWN (TIMEOUT overrides).
    - On the edge leaving CHECK: last_status, last_cycles=cyc and the matching counter update, and status_valid=1 for that single following cycle.
  - NEXT: if single=1 or test_sel==NUM_TESTS-1, go to DONE; else test_sel++ and go to LOAD.
  - DONE: done=1, cpu_rst=1; start goes to LOAD.
- Start handling:
  - start from IDLE/DONE clears all four counters, last_status, last_cycles and the latched single mode.
  - It also sets test_sel = single ? test_id : 0.
  - start while busy is ignored.
- Counters saturate at 2^CNT_W-1; no wrap.
- abort takes priority over start and over every transition; status_valid is not generated for an aborted test.
- reset asserted mid-test returns to the reset values immediately, asynchronously; cpu_rst goes to 1 without waiting for a clock.
- load_done asserted outside LOAD is ignored.
- test_id >= NUM_TESTS in single mode: clamp test_sel to NUM_TESTS-1.

Test Plan:
- Single mode, test_id=3, load_done 2 cycles after load_req, instr=HALT_INSTR on RUN cycle 40, result=00c0ffee -> last_status=0, last_cycles=40, pass_count=1, status_valid pulses once, done=1.
- Batch NUM_TESTS=4, results c0ffee/deaddead/12345678/c0ffee -> pass=2, fail=1, unknown=1; test_sel sequences 0,1,2,3; cpu_rst re-asserts for 2 cycles before each RUN.
- MAX_CYCLES=50, halt never seen -> TIMEOUT with last_cycles=49, timeout_count=1; halt on cycle 49 in a second run -> PASS/FAIL, not timeout.
- CNT_W=2, 5 passing tests -> pass_count saturates at 3.
- abort asserted in RUN at cycle 10 -> IDLE next cycle, cpu_rst=1, busy=0, no status_valid; then reset=0 mid-LOAD -> all outputs at reset values without a clock edge.
- start pulsed during RUN -> ignored; start in DONE -> counters cleared and batch restarts at test 0.
